// File: rtl/seq_alu_pkg.sv
// seq_alu shared types: op codes and FSM states.
// Divider built only when SEQ_ALU_DIV_EN is defined.
package seq_alu_pkg;

  localparam logic [1:0] ENC_ADD = 2'b00;
  localparam logic [1:0] ENC_SUB = 2'b01;
  localparam logic [1:0] ENC_MUL = 2'b10;
  localparam logic [1:0] ENC_DIV = 2'b11;

  typedef enum logic [1:0] {
    OP_ADD = ENC_ADD,
    OP_SUB = ENC_SUB,
    OP_MUL = ENC_MUL,
    OP_DIV = ENC_DIV
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_alu_div.sv
// Restoring unsigned divider: iteration registers and one step.
// Instantiated by seq_alu only when SEQ_ALU_DIV_EN is defined.
module seq_alu_div
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic             ge;

  // quo doubles as the dividend shift register
  always_comb begin
    shl     = {rem, quo[WIDTH-1]};
    diff    = shl - {1'b0, dvs};
    ge      = (shl >= {1'b0, dvs});
    rem_nxt = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= a;
      dvs <= b;
    end else if (step) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: add/sub, Booth multiply, restoring divide.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise op=11 errors.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               valid,
  output logic [2*WIDTH-1:0] result,
  output logic               err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = 2 * WIDTH;

  state_t state;
  state_t state_nxt;
  state_t req_state;
  op_t    op_i;

  logic          accept;
  logic          last;
  logic [CW-1:0] cnt;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   m_neg;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic [RW-1:0]    mul_res;
  logic [RW-1:0]    a_sx;
  logic [RW-1:0]    b_sx;

  assign op_i   = op_t'(op);
  assign accept = start && ready;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};

  always_comb begin
    req_state = S_DONE;
    unique case (1'b1)
      (op_i == OP_MUL): req_state = S_MUL;
`ifdef SEQ_ALU_DIV_EN
      (op_i == OP_DIV) && (b != '0): req_state = S_DIV;
`endif
      default: req_state = S_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = req_state;
      S_MUL:  if (last)  state_nxt = S_DONE;
      S_DIV:  if (last)  state_nxt = S_DONE;
      S_DONE: state_nxt = start ? req_state : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == S_IDLE) || (state == S_DONE);
    valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (accept)
      cnt <= '0;
    else if (state == S_MUL || state == S_DIV)
      cnt <= cnt + 1'b1;
  end

  // Booth step: add per {q0,q_1}, then arithmetic shift right
  always_comb begin
    sum = acc;
    unique case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc + m_neg;
      default: sum = acc;
    endcase
    acc_sh  = {sum[WIDTH], sum[WIDTH:1]};
    q_sh    = {sum[0], q[WIDTH-1:1]};
    mul_res = {acc_sh[WIDTH-1:0], q_sh};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      m     <= '0;
      m_neg <= '0;
    end else if (accept) begin
      acc   <= '0;
      q     <= b;
      q_1   <= 1'b0;
      m     <= {a[WIDTH-1], a};
      m_neg <= -{a[WIDTH-1], a};
    end else if (state == S_MUL) begin
      acc   <= acc_sh;
      q     <= q_sh;
      q_1   <= q[0];
    end
  end

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && op_i == OP_DIV),
    .step   (state == S_DIV),
    .a      (a),
    .b      (b),
    .rem_nxt(rem_nxt),
    .quo_nxt(quo_nxt)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      unique case (op_i)
        OP_ADD: begin
          result <= a_sx + b_sx;
          err    <= 1'b0;
        end
        OP_SUB: begin
          result <= a_sx - b_sx;
          err    <= 1'b0;
        end
        OP_MUL: ;
        OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
          if (b == '0) begin
            result <= {a, {WIDTH{1'b1}}};
            err    <= 1'b1;
          end
`else
          result <= '0;
          err    <= 1'b1;
`endif
        end
        default: ;
      endcase
    end else if (state == S_MUL && last) begin
      result <= mul_res;
      err    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
    end else if (state == S_DIV && last) begin
      result <= {rem_nxt, quo_nxt};
      err    <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle integer ALU for the calculator datapath. Accepts one operation at a time through a start/ready handshake and returns a double-width result with a one-cycle valid pulse. Supports signed add/sub, signed Booth multiply (correct for the most-negative multiplicand) and unsigned restoring divide with a divide-by-zero flag. It sits between the keypad/operand registers and the display formatter.

## Interface
- WIDTH, default 4, operand width in bits; legal range 2..16.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted on a rising edge where start && ready.
- op  in  2  operation: 2'b00 add, 2'b01 sub, 2'b10 mul, 2'b11 div.
- a  in  WIDTH  operand A: signed for add/sub/mul, unsigned dividend for div.
- b  in  WIDTH  operand B: signed for add/sub/mul, unsigned divisor for div.
- ready  out  1  block can accept a request this cycle.
- valid  out  1  one-cycle pulse; result and err are valid.
- result  out  2*WIDTH  add/sub/mul: signed sum, difference or product; div: {remainder, quotient}.
- err  out  1  divide-by-zero, qualified by valid.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. ready = (state == IDLE) || (state == DONE).
- On accept, latch op, a and b. start while ready=0 is ignored, and the operands are not sampled.
- Add/sub: sign-extend both operands to 2*WIDTH, compute the result, go to DONE. No overflow is possible.
- Mul: radix-2 Booth, WIDTH iterations, one per cycle in MUL.
  - Register layout: {acc[WIDTH:0], q[WIDTH-1:0], q_1}.
  - The multiplicand and its negation are held sign-extended to WIDTH+1 bits, so -2^(WIDTH-1) does not overflow.
  - Each cycle: add M if {q0,q_1}=01, add -M if 10, then arithmetic shift right by one.
  - result = low 2*WIDTH bits of {acc,q} after the final shift.
- Div: restoring, unsigned, WIDTH iterations in DIV.
  - Each iteration shifts the partial remainder left, compares it with b, and subtracts and sets the quotient bit when it is not smaller.
  - Remainder is in result[2*WIDTH-1:WIDTH], quotient in result[WIDTH-1:0].
- Divide by zero (b == 0): skip DIV and go straight to DONE with err=1, quotient all ones, remainder = a.
- Iteration counter is $clog2(WIDTH+1) bits, cleared on accept. MUL/DIV exits to DONE when the counter reaches WIDTH-1 at the end of that iteration.
- DONE: valid=1 for exactly one cycle.
  - Then go to IDLE, or, if a new request is accepted in DONE, to the state for that request.
- result and err hold their value until the next result is written. err clears on any non-error completion.

## Timing
- Reset values (after the reset edge): state IDLE, ready=1, valid=0, result=0, err=0, counter=0.
- Accept at edge k:
  - Add, sub and divide-by-zero: valid is high in the cycle after edge k+1.
  - Mul and div: valid is high in the cycle after edge k+WIDTH+1, i.e. latency WIDTH+1.
- ready is low from edge k+1 until the DONE cycle, and high again in the DONE cycle. Back-to-back throughput is therefore one request per latency period.
- rst asserted mid-operation aborts the operation: no valid pulse, ready=1 next cycle, partial state discarded.
- rst takes priority over start in the same cycle; that request is dropped.

## Configuration
- SEQ_ALU_DIV_EN defined: the divider and DIV state are built, and op=11 behaves as described above.
- SEQ_ALU_DIV_EN undefined: no divider logic. op=11 goes straight to DONE with err=1 and result=0, latency 1.

## Structure
- Package seq_alu_pkg holds:
  - the op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
  - the state_t enum (S_IDLE, S_MUL, S_DIV, S_DONE);
  - the op encoding constants.
- Sub-module seq_alu_div holds the restoring-divide iteration register and step logic. It is instantiated only under SEQ_ALU_DIV_EN.
- Booth multiply, add/sub and the FSM stay in seq_alu.

## Test plan
All scenarios use WIDTH=4.
- Add a=4'h7, b=4'h8 (-8): result 8'hFF (-1), valid 1 cycle after accept, err=0.
- Mul a=4'h8 (-8), b=4'h8 (-8): result 8'h40 (64), valid exactly 5 cycles after accept. Then mul a=3, b=4'hE (-2): result 8'hFA.
- Div a=13, b=4: result 8'h13 (remainder 1, quotient 3), latency 5. Div a=9, b=0: err=1, result 8'h9F, latency 1.
- Back-to-back: second start held high through the DONE cycle of a mul is accepted there. start pulses while ready=0 are ignored, and the operands are not resampled.
- Reset mid-operation: assert rst 2 cycles into a mul. No valid pulse, ready=1, result=0 the next cycle.
- Build without SEQ_ALU_DIV_EN: op=11 gives err=1, result=0, latency 1. Add/sub/mul results are unchanged.
